// File: rtl/mux_nto1_pipe.sv
// NUM_IN:1 selector feeding a two-entry valid/ready skid buffer (main + skid register).
// Optional macro MUXN_BYPASS_EN: zero-latency pass-through when empty and downstream is ready.
module mux_nto1_pipe #(
  parameter int              WIDTH     = 32,
  parameter int              NUM_IN    = 4,
  parameter int              SEL_W     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_selErr;

  logic [WIDTH-1:0] w_word;
  logic             w_selOk;
  logic             w_accept;
  logic             w_drain;
  logic             w_bypass;

  // Out-of-range selects yield zero and are flagged instead of aliasing onto a real input.
  always_comb begin
    w_word  = '0;
    w_selOk = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        w_word  = in_data[k*WIDTH +: WIDTH];
        w_selOk = 1'b1;
      end
    end
  end

`ifdef MUXN_BYPASS_EN
  assign w_bypass = (r_state == EMPTY) & in_valid & out_ready & ~reset;
`else
  assign w_bypass = 1'b0;
`endif

  assign in_ready  = (r_state != TWO) & ~reset;
  assign out_valid = (r_state != EMPTY) | w_bypass;
  assign out_data  = w_bypass ? w_word : r_main;
  assign sel_err   = r_selErr;

  assign w_accept = in_valid & in_ready;
  assign w_drain  = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= EMPTY;
      r_main   <= RESET_VAL;
      r_skid   <= '0;
      r_selErr <= 1'b0;
    end else begin
      if (w_accept && !w_selOk)
        r_selErr <= 1'b1;
      case (r_state)
        EMPTY: begin
          // A bypassed beat still lands in main so out_data holds it afterwards.
          if (w_accept) begin
            r_main <= w_word;
            if (!w_bypass)
              r_state <= ONE;
          end
        end
        ONE: begin
          if (w_accept && w_drain) begin
            r_main <= w_word;
          end else if (w_accept) begin
            r_skid  <= w_word;
            r_state <= TWO;
          end else if (w_drain) begin
            r_state <= EMPTY;
          end
        end
        TWO: begin
          if (w_drain) begin
            r_main  <= r_skid;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule
